// File: rtl/multicycle_maindec.sv
// Multicycle RV32I main decoder: Moore FSM sequencing one instruction over a shared ALU and memory port.
// Define MAINFSM_INSTRET_EN to build the retired-instruction counter (instret, CNT_W bits).
module multicycle_maindec #(
  parameter int MEM_TIMEOUT = 16
`ifdef MAINFSM_INSTRET_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       trap_ack,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MAINFSM_INSTRET_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The wait counter only ever holds 0..MEM_TIMEOUT-1; the trap fires on the cycle it would reach the limit.
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] LIMIT = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_t;

  state_t          state;
  logic [WW-1:0]   waitcnt;
  logic            mem_timeout;

  assign mem_timeout = !mem_ready && (waitcnt == LIMIT);

`ifdef MAINFSM_INSTRET_EN
  logic retire;
  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                  ((state == MEMWRITE) && mem_ready) ||
                  ((state == DECODE) && (op == OP_FENCE));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      waitcnt    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
`ifdef MAINFSM_INSTRET_EN
      instret    <= '0;
`endif
    end else begin
      waitcnt <= '0;
`ifdef MAINFSM_INSTRET_EN
      if (retire) instret <= instret + CNT_W'(1);
`endif
      case (state)
        FETCH: begin
          if (mem_ready) state <= DECODE;
          else if (mem_timeout) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
          end else waitcnt <= waitcnt + WW'(1);
        end
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXECR;
            OP_ITYPE:          state <= EXECI;
            OP_BRANCH:         state <= BRANCH;
            OP_JAL:            state <= JAL;
            OP_JALR:           state <= JALR;
            OP_LUI:            state <= LUI;
            OP_AUIPC:          state <= AUIPC;
            OP_FENCE:          state <= FETCH;
            OP_SYSTEM: begin
              state      <= TRAP;
              trap       <= 1'b1;
              trap_cause <= 2'd2;
            end
            default: begin
              state      <= TRAP;
              trap       <= 1'b1;
              trap_cause <= 2'd1;
            end
          endcase
        end
        MEMADR: state <= (op == OP_STORE) ? MEMWRITE : MEMREAD;
        MEMREAD: begin
          if (mem_ready) state <= MEMWB;
          else if (mem_timeout) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
          end else waitcnt <= waitcnt + WW'(1);
        end
        MEMWRITE: begin
          if (mem_ready) state <= FETCH;
          else if (mem_timeout) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
          end else waitcnt <= waitcnt + WW'(1);
        end
        MEMWB, ALUWB, BRANCH: state <= FETCH;
        EXECR, EXECI, LUI, AUIPC, JAL: state <= ALUWB;
        JALR: state <= JAL;
        TRAP: begin
          if (trap_ack) begin
            state      <= FETCH;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
          end
        end
        default: begin
          state      <= FETCH;
          trap       <= 1'b0;
          trap_cause <= 2'd0;
        end
      endcase
    end
  end

  // Moore decode; only the FETCH strobes look at mem_ready directly.
  always_comb begin
    mem_req   = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE, AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR, JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      JAL: begin
        PCUpdate = 1'b1;
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Table-driven bench for multicycle_maindec (MEM_TIMEOUT = 4); the instret checks build only with MAINFSM_INSTRET_EN.
module tb_multicycle_maindec;

  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_ILL   = 7'b1111111;

  // {mem_req,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,AdrSrc, ALUSrcA,ALUSrcB,ResultSrc,ALUOp}
  localparam logic [14:0] C_FETCH1 = 15'b1110000_00_10_10_00;
  localparam logic [14:0] C_FETCH0 = 15'b1000000_00_10_10_00;
  localparam logic [14:0] C_DECODE = 15'b0000000_01_01_00_00;
  localparam logic [14:0] C_MEMADR = 15'b0000000_10_01_00_00;
  localparam logic [14:0] C_MEMRD  = 15'b1000001_00_00_00_00;
  localparam logic [14:0] C_MEMWB  = 15'b0000100_00_00_01_00;
  localparam logic [14:0] C_MEMWR  = 15'b1000011_00_00_00_00;
  localparam logic [14:0] C_EXECR  = 15'b0000000_10_00_00_10;
  localparam logic [14:0] C_EXECI  = 15'b0000000_10_01_00_10;
  localparam logic [14:0] C_ALUWB  = 15'b0000100_00_00_00_00;
  localparam logic [14:0] C_BRANCH = 15'b0001000_10_00_00_01;
  localparam logic [14:0] C_JAL    = 15'b0010000_01_10_00_00;
  localparam logic [14:0] C_JALR   = 15'b0000000_10_01_00_00;
  localparam logic [14:0] C_LUI    = 15'b0000000_11_01_00_00;
  localparam logic [14:0] C_AUIPC  = 15'b0000000_01_01_00_00;
  localparam logic [14:0] C_TRAP   = 15'b0000000_00_00_00_00;

  logic       clk = 1'b0;
  logic       reset, mem_ready, trap_ack;
  logic [6:0] op;
  logic       mem_req, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc, trap;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, trap_cause;
  logic [2:0] ImmSrc;
  logic [14:0] ctl;
`ifdef MAINFSM_INSTRET_EN
  logic [3:0] instret;
`endif

  int tests = 0;
  int fails = 0;

  multicycle_maindec #(
    .MEM_TIMEOUT(4)
`ifdef MAINFSM_INSTRET_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .trap_ack(trap_ack),
    .mem_req(mem_req), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .trap(trap), .trap_cause(trap_cause)
`ifdef MAINFSM_INSTRET_EN
    , .instret(instret)
`endif
  );

  assign ctl = {mem_req, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUOp};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic        ack;
    logic [14:0] ctl;
    logic [2:0]  imm;
    logic        trp;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [6:0] o, input logic rd, input logic a,
                     input logic [14:0] c, input logic [2:0] im, input logic t, input logic [1:0] ca);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = rd; v.ack = a; v.ctl = c; v.imm = im; v.trp = t; v.cause = ca;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] o, input logic rd, input logic a);
    reset = r; op = o; mem_ready = rd; trap_ack = a;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    applyStimulus(1'b1, 7'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then R-type
    add(0, OP_R, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_R, 1, 0, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_DECODE, 3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_EXECR,  3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_ALUWB,  3'd0, 0, 2'd0);
    // Load with three stall cycles
    add(0, OP_LD, 1, 0, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_LD, 0, 0, C_DECODE, 3'd0, 0, 2'd0);
    add(0, OP_LD, 0, 0, C_MEMADR, 3'd0, 0, 2'd0);
    add(0, OP_LD, 0, 0, C_MEMRD,  3'd0, 0, 2'd0);
    add(0, OP_LD, 0, 0, C_MEMRD,  3'd0, 0, 2'd0);
    add(0, OP_LD, 0, 0, C_MEMRD,  3'd0, 0, 2'd0);
    add(0, OP_LD, 1, 0, C_MEMRD,  3'd0, 0, 2'd0);
    add(0, OP_LD, 0, 0, C_MEMWB,  3'd0, 0, 2'd0);
    // Store, I-type, branch, LUI, AUIPC
    add(0, OP_ST, 1, 0, C_FETCH1, 3'd1, 0, 2'd0);
    add(0, OP_ST, 0, 0, C_DECODE, 3'd1, 0, 2'd0);
    add(0, OP_ST, 0, 0, C_MEMADR, 3'd1, 0, 2'd0);
    add(0, OP_ST, 1, 0, C_MEMWR,  3'd1, 0, 2'd0);
    add(0, OP_I, 1, 0, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_I, 0, 0, C_DECODE, 3'd0, 0, 2'd0);
    add(0, OP_I, 0, 0, C_EXECI,  3'd0, 0, 2'd0);
    add(0, OP_I, 0, 0, C_ALUWB,  3'd0, 0, 2'd0);
    add(0, OP_BR, 1, 0, C_FETCH1, 3'd2, 0, 2'd0);
    add(0, OP_BR, 0, 0, C_DECODE, 3'd2, 0, 2'd0);
    add(0, OP_BR, 0, 0, C_BRANCH, 3'd2, 0, 2'd0);
    add(0, OP_LUI, 1, 0, C_FETCH1, 3'd4, 0, 2'd0);
    add(0, OP_LUI, 0, 0, C_DECODE, 3'd4, 0, 2'd0);
    add(0, OP_LUI, 0, 0, C_LUI,    3'd4, 0, 2'd0);
    add(0, OP_LUI, 0, 0, C_ALUWB,  3'd4, 0, 2'd0);
    add(0, OP_AUIPC, 1, 0, C_FETCH1, 3'd4, 0, 2'd0);
    add(0, OP_AUIPC, 0, 0, C_DECODE, 3'd4, 0, 2'd0);
    add(0, OP_AUIPC, 0, 0, C_AUIPC,  3'd4, 0, 2'd0);
    add(0, OP_AUIPC, 0, 0, C_ALUWB,  3'd4, 0, 2'd0);
    // FENCE goes straight back to FETCH; trap_ack outside TRAP is ignored
    add(0, OP_FENCE, 1, 1, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_FENCE, 0, 1, C_DECODE, 3'd0, 0, 2'd0);
    // JALR -> JAL -> ALUWB
    add(0, OP_JALR, 1, 0, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_JALR, 0, 0, C_DECODE, 3'd0, 0, 2'd0);
    add(0, OP_JALR, 0, 0, C_JALR,   3'd0, 0, 2'd0);
    add(0, OP_JALR, 0, 0, C_JAL,    3'd0, 0, 2'd0);
    add(0, OP_JALR, 0, 0, C_ALUWB,  3'd0, 0, 2'd0);
    // JAL abandoned by reset
    add(0, OP_JAL, 1, 0, C_FETCH1, 3'd3, 0, 2'd0);
    add(0, OP_JAL, 0, 0, C_DECODE, 3'd3, 0, 2'd0);
    add(1, OP_JAL, 0, 0, C_JAL,    3'd3, 0, 2'd0);
    add(0, OP_JAL, 1, 0, C_FETCH1, 3'd3, 0, 2'd0);
    add(0, OP_JAL, 0, 0, C_DECODE, 3'd3, 0, 2'd0);
    add(0, OP_JAL, 0, 0, C_JAL,    3'd3, 0, 2'd0);
    add(0, OP_JAL, 0, 0, C_ALUWB,  3'd3, 0, 2'd0);
    // Illegal opcode trap, held until trap_ack
    add(0, OP_ILL, 1, 0, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_ILL, 0, 0, C_DECODE, 3'd0, 0, 2'd0);
    add(0, OP_ILL, 1, 0, C_TRAP,   3'd0, 1, 2'd1);
    add(0, OP_ILL, 0, 1, C_TRAP,   3'd0, 1, 2'd1);
    // Fetch timeout after four wait cycles
    add(0, OP_ILL, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_ILL, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_ILL, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_ILL, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_ILL, 0, 0, C_TRAP,   3'd0, 1, 2'd3);
    add(0, OP_ILL, 0, 1, C_TRAP,   3'd0, 1, 2'd3);
    // SYSTEM trap abandoned by reset
    add(0, OP_SYS, 1, 0, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_SYS, 0, 0, C_DECODE, 3'd0, 0, 2'd0);
    add(1, OP_SYS, 0, 0, C_TRAP,   3'd0, 1, 2'd2);
    // mem_ready on the limit cycle wins over the timeout
    add(0, OP_R, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_FETCH0, 3'd0, 0, 2'd0);
    add(0, OP_R, 1, 0, C_FETCH1, 3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_DECODE, 3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_EXECR,  3'd0, 0, 2'd0);
    add(0, OP_R, 0, 0, C_ALUWB,  3'd0, 0, 2'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].ack);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), {11'd0, ctl, ImmSrc, trap, trap_cause},
                  {11'd0, vecs[i].ctl, vecs[i].imm, vecs[i].trp, vecs[i].cause});
      step();
    end

    // Store stuck in MEMWRITE: bounded wait for the timeout trap
    applyStimulus(0, OP_ST, 1, 0); step();
    applyStimulus(0, OP_ST, 0, 0); step();
    step();
    n = 0;
    while (trap !== 1'b1 && n < 20) begin
      @(negedge clk);
      checkOutput($sformatf("memwr_wait%0d", n), {31'd0, MemWrite}, 32'd1);
      step();
      n++;
    end
    checkOutput("memwr_timeout_cycles", n, 32'd4);
    checkOutput("memwr_timeout_cause", {30'd0, trap_cause}, 32'd3);
    applyStimulus(0, OP_ST, 0, 1); step();
    applyStimulus(0, OP_ST, 0, 0);
    @(negedge clk);
    checkOutput("memwr_trap_exit", {29'd0, trap, mem_req, MemWrite}, 32'b010);

`ifdef MAINFSM_INSTRET_EN
    step();
    applyStimulus(1, OP_I, 0, 0); step();
    applyStimulus(0, OP_I, 0, 0);
    checkOutput("instret_reset", {28'd0, instret}, 32'd0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(0, OP_I, 1, 0); step();
      applyStimulus(0, OP_I, 0, 0); step();
      step();
      step();
    end
    checkOutput("instret_wrap", {28'd0, instret}, 32'd1);
    applyStimulus(0, OP_ILL, 1, 0); step();
    applyStimulus(0, OP_ILL, 0, 0); step();
    applyStimulus(0, OP_ILL, 0, 1); step();
    applyStimulus(0, OP_ILL, 0, 0); step();
    checkOutput("instret_trap_exit", {28'd0, instret}, 32'd1);
    applyStimulus(0, OP_FENCE, 1, 0); step();
    applyStimulus(0, OP_FENCE, 0, 0); step();
    checkOutput("instret_fence", {28'd0, instret}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Multicycle successor to the single-cycle RV32I main decoder: a Moore FSM that sequences one instruction over several cycles on a shared datapath (one ALU, one memory port).
- It drives the datapath mux selects and write enables, and handshakes with a memory port that may stall.
- It traps on illegal or SYSTEM opcodes and on memory timeout.
- It sits in the controller, beside aludec, which consumes ALUOp.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles a memory request may wait for mem_ready before a timeout trap. Minimum 1.
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op  in  7  opcode field of the instruction register
- mem_ready  in  1  memory completes the current request this cycle
- trap_ack  in  1  trap handler acknowledges the trap
- mem_req  out  1  memory request valid
- IRWrite  out  1  load the instruction register
- PCUpdate  out  1  unconditional PC write
- Branch  out  1  conditional PC write (gated by Zero in the datapath)
- RegWrite  out  1  register file write enable
- MemWrite  out  1  store enable, qualified by mem_req
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = funct-decoded
- ImmSrc  out  3  combinational from op: I = 000, S = 001, B = 010, J = 011, U = 100, otherwise 000
- trap  out  1  trap pending
- trap_cause  out  2  1 = illegal opcode, 2 = SYSTEM, 3 = memory timeout
- instret  out  CNT_W  retired instructions (MAINFSM_INSTRET_EN only)

Behaviour:
- Outputs are Moore, decoded from state only, except the mem_ready-qualified strobes in FETCH.
- Any output not listed for a state is 0.
- Reset (synchronous): state goes to FETCH, the wait counter clears, trap = 0, trap_cause = 0. Reset mid-instruction or mid-trap abandons it.
- FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ResultSrc = 10. IRWrite and PCUpdate both equal mem_ready. Moves to DECODE on mem_ready.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch/JAL target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - 0001111 (FENCE) -> FETCH as a no-op
  - 1110011 -> TRAP, cause 2
  - anything else -> TRAP, cause 1
- MEMADR: ALUSrcA = 10, ALUSrcB = 01. Goes to MEMREAD for loads, MEMWRITE for stores; the opcode is resampled from the held IR.
- MEMREAD: mem_req = 1, AdrSrc = 1. Moves to MEMWB on mem_ready.
- MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
- MEMWRITE: mem_req = 1, MemWrite = 1, AdrSrc = 1. Moves to FETCH on mem_ready.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10, then ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10, then ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1, then FETCH.
- JAL: PCUpdate = 1, ResultSrc = 00, ALUSrcA = 01, ALUSrcB = 10, then ALUWB (link = OldPC + 4).
- JALR: ALUSrcA = 10, ALUSrcB = 01, then JAL, which reuses the JAL outputs.
- LUI: ALUSrcA = 11, ALUSrcB = 01, then ALUWB.
- AUIPC: ALUSrcA = 01, ALUSrcB = 01, then ALUWB.
- Memory wait counter:
  - Clears on entry to any mem_req state; counts each cycle that mem_req = 1 and mem_ready = 0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, the FSM goes to TRAP with cause 3.
  - mem_ready in the same cycle as the count reaching the limit wins: normal progress, no trap.
- TRAP: trap = 1, all enables 0, trap_cause held. Returns to FETCH the cycle after trap_ack = 1, clearing trap and trap_cause. trap_ack outside TRAP is ignored.
- Unreachable state encodings go to FETCH.

Optional Feature:
- MAINFSM_INSTRET_EN defined:
  - instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, or DECODE (FENCE). Not on TRAP exit.
  - Wraps modulo 2^CNT_W.
  - Clears on reset.
- Not defined: the instret port does not exist and no counter logic is built.

Test Plan:
- R-type: op = 0110011, mem_ready = 1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite = 1 only in ALUWB; ALUOp = 10 in EXECR.
- Load with 3-cycle memory stall: op = 0000011, mem_ready low for 3 cycles in MEMREAD -> mem_req held 4 cycles, then MEMWB with ResultSrc = 01 and RegWrite = 1. Total 8 cycles, no trap.
- Timeout with MEM_TIMEOUT = 4, mem_ready stuck at 0 in FETCH -> trap = 1 and trap_cause = 3 after 4 wait cycles. trap_ack -> FETCH next cycle, trap = 0.
- Illegal and SYSTEM opcodes: op = 1111111 -> TRAP with cause 1; op = 1110011 -> TRAP with cause 2; FENCE 0001111 -> FETCH directly after DECODE, no trap.
- JALR then reset: JALR, JAL (PCUpdate = 1), ALUWB (RegWrite = 1). reset asserted in JAL -> next cycle FETCH with all enables 0.
- MAINFSM_INSTRET_EN with CNT_W = 4: retire 17 ALU instructions -> instret = 1 (wrap). A trap exit leaves instret unchanged.
